// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the requester, serializer and arbiter-status signals around uart_tx_arbiter.
// master: requesters plus the uart_tx completion pulse; slave: the arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic                 err;
    logic                 busy;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_done;

    modport master (
        output req, req_data, tx_done,
        input  grant, done, err, busy, tx_data, tx_start
    );

    modport slave (
        input  req, req_data, tx_done,
        output grant, done, err, busy, tx_data, tx_start
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among NUM_REQ byte requesters with a transfer watchdog.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter logic [23:0] TX_TIMEOUT = 24'd2_000_000
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned IdxW  = $clog2(NUM_REQ);
    localparam int unsigned IdxW1 = IdxW + 1;
    localparam logic [IdxW:0] NumReqW = IdxW1'(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StGap} state_e;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 err_q, err_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [23:0]          cnt_q, cnt_d;

    logic                 win_found;
    logic [IdxW-1:0]      win_idx;
    logic [IdxW:0]        cand;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [7:0]           win_byte;
    logic [IdxW-1:0]      ptr_adv;

    // Search upward from the pointer, wrapping at NUM_REQ (not at 2**IdxW).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + IdxW1'(k);
            if (cand >= NumReqW) begin
                cand = cand - NumReqW;
            end
            if (!win_found && bus.req[cand[IdxW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        win_byte   = '0;
        win_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IdxW'(i)) begin
                win_byte      = bus.req_data[8*i +: 8];
                win_onehot[i] = 1'b1;
            end
        end
    end

`ifdef UART_ARB_FIXED_PRIO_EN
    assign ptr_adv = '0;
`else
    logic [IdxW-1:0] owner_idx;

    always_comb begin
        owner_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx = IdxW'(i);
            end
        end
    end

    assign ptr_adv = (owner_idx == IdxW'(NUM_REQ - 1)) ? '0 : owner_idx + IdxW'(1);
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        done_d     = '0;
        err_d      = 1'b0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    tx_data_d  = win_byte;
                    grant_d    = win_onehot;
                    tx_start_d = 1'b1;
                    state_d    = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 24'd1;
                // A real completion wins over a timeout landing on the same cycle.
                if (bus.tx_done || (cnt_q == TX_TIMEOUT - 24'd1)) begin
                    err_d   = !bus.tx_done;
                    done_d  = grant_q;
                    grant_d = '0;
                    ptr_d   = ptr_adv;
                    cnt_d   = '0;
                    state_d = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: scoreboard of expected (grant, byte) per tx_start,
// with the serializer modelled inline by delayed tx_done pulses.
module tb_uart_tx_arbiter;
    localparam int unsigned NReq  = 4;
    localparam int          Frame = 20;

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc;
    int   k;
    exp_t sb_q[$];
    logic [3:0] cur_grant;

    uart_tx_arbiter_if #(.NUM_REQ(NReq)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ   (NReq),
        .TX_TIMEOUT(24'd100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [7:0] d);
        sb_q.push_back({g, d});
    endtask

    // Waits for tx_start, checks it against the oldest scoreboard entry, then checks it drops.
    task automatic wait_start(input string tag, output int waited);
        exp_t e;
        waited = 0;
        @(negedge clk);
        waited = 1;
        while (bus.tx_start !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_start"}, {31'd0, bus.tx_start}, 32'd1);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s_sb: observed tx_start %0h with nothing expected", tag, bus.tx_data);
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        cur_grant = e.grant;
        chk({tag, "_data"}, {24'd0, bus.tx_data}, {24'd0, e.data});
        chk({tag, "_grant"}, {28'd0, bus.grant}, {28'd0, e.grant});
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        chk({tag, "_start_pulse"}, {31'd0, bus.tx_start}, 32'd0);
    endtask

    task automatic finish_tx(input string tag);
        repeat (Frame) @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        chk({tag, "_done"}, {28'd0, bus.done}, {28'd0, cur_grant});
        chk({tag, "_grant_clr"}, {28'd0, bus.grant}, 32'd0);
        chk({tag, "_no_err"}, {31'd0, bus.err}, 32'd0);
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        chk({tag, "_done_clr"}, {28'd0, bus.done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.tx_done  = 1'b0;
        cur_grant    = '0;
        #1;
        chk("rst_grant", {28'd0, bus.grant}, 32'd0);
        chk("rst_done", {28'd0, bus.done}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        chk("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // All four requesting continuously.
        bus.req_data = 32'h1312_1110;
        bus.req      = 4'b1111;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 5; i++) push(4'b0001, 8'h10);
`else
        push(4'b0001, 8'h10);
        push(4'b0010, 8'h11);
        push(4'b0100, 8'h12);
        push(4'b1000, 8'h13);
        push(4'b0001, 8'h10);
`endif
        for (int i = 0; i < 5; i++) begin
            wait_start("rr", cyc);
            finish_tx("rr");
            after_done("rr");
        end

        // Requester 3 wins, then 4'b1001 must go 0 then 3.
        bus.req = 4'b1000;
        push(4'b1000, 8'h13);
        wait_start("wrap3", cyc);
        finish_tx("wrap3");
        after_done("wrap3");
        bus.req = 4'b1001;
        push(4'b0001, 8'h10);
`ifdef UART_ARB_FIXED_PRIO_EN
        push(4'b0001, 8'h10);
`else
        push(4'b1000, 8'h13);
`endif
        wait_start("wrap0", cyc);
        finish_tx("wrap0");
        after_done("wrap0");
        wait_start("wrap_next", cyc);
        finish_tx("wrap_next");
        bus.req = 4'b0000;
        after_done("wrap_next");

        // Single request on requester 2.
        bus.req_data[23:16] = 8'hA5;
        bus.req             = 4'b0100;
        push(4'b0100, 8'hA5);
        wait_start("single", cyc);
        finish_tx("single");
        bus.req = 4'b0000;
        after_done("single");
        repeat (3) @(negedge clk);
        chk("tx_data_hold", {24'd0, bus.tx_data}, 32'hA5);

        // Back-to-back: byte changes on the done cycle, next start two cycles after done.
        bus.req_data[15:8] = 8'h3C;
        bus.req            = 4'b0010;
        push(4'b0010, 8'h3C);
        wait_start("b2b_a", cyc);
        bus.req_data[15:8] = 8'hEE;
        finish_tx("b2b_a");
        bus.req_data[15:8] = 8'h5A;
        push(4'b0010, 8'h5A);
        after_done("b2b_a");
        wait_start("b2b_b", cyc);
        chk("b2b_spacing", cyc, 32'd1);
        finish_tx("b2b_b");
        bus.req = 4'b0000;
        after_done("b2b_b");

        // Watchdog: tx_done never comes.
        bus.req = 4'b0001;
        push(4'b0001, 8'h10);
        wait_start("timeout", cyc);
        k = 1;
        while (bus.err !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        // k counts from the START cycle, so WAIT entry plus 100 cycles lands on 101.
        chk("timeout_cycles", k, 32'd101);
        chk("timeout_done", {28'd0, bus.done}, 32'b0001);
        chk("timeout_grant_clr", {28'd0, bus.grant}, 32'd0);
        bus.req = 4'b0000;
        @(negedge clk);
        chk("timeout_err_clr", {31'd0, bus.err}, 32'd0);
        chk("timeout_idle", {31'd0, bus.busy}, 32'd0);

        // Reset during WAIT, stray tx_done afterwards.
        bus.req_data[15:8] = 8'h11;
        bus.req            = 4'b0010;
        push(4'b0010, 8'h11);
        wait_start("mid_rst", cyc);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_grant", {28'd0, bus.grant}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        chk("mid_rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
        bus.req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_done", {28'd0, bus.done}, 32'd0);
        end

        bus.req = 4'b0100;
        push(4'b0100, 8'hA5);
        wait_start("post_rst", cyc);
        finish_tx("post_rst");
        bus.req = 4'b0000;
        after_done("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
